// File: rtl/rcp_fifo_flex.sv
// Synchronous FIFO of arbitrary depth with show-ahead output, occupancy count,
// programmable almost-full/almost-empty levels, flush and overflow/underflow pulses.
module rcp_fifo_flex #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 4,
  parameter int AF_LEVEL = DEPTH - 1,
  parameter int AE_LEVEL = 1,
  localparam int ADD_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_WIDTH = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     in_data,
  input  logic                 enq,
  input  logic                 deq,
  input  logic                 flush,
  output logic [WIDTH-1:0]     out_data,
  output logic                 empty,
  output logic                 full,
  output logic                 almost_full,
  output logic                 almost_empty,
  output logic [CNT_WIDTH-1:0] count,
  output logic                 overflow,
  output logic                 underflow
);

  logic [WIDTH-1:0]     mem_q [DEPTH];
  logic [ADD_WIDTH-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic                 empty_q, empty_d, full_q, full_d;
  logic                 af_q, af_d, ae_q, ae_d;
  logic                 ovf_q, ovf_d, unf_q, unf_d;
  logic                 wr_acc, rd_acc;

  // Explicit wrap so non-power-of-two depths never index past DEPTH-1.
  function automatic logic [ADD_WIDTH-1:0] ptr_inc(input logic [ADD_WIDTH-1:0] p);
    if (p == ADD_WIDTH'(DEPTH - 1)) return '0;
    return p + 1'b1;
  endfunction

  // A write into a full FIFO is only legal when the head leaves on the same edge.
  assign wr_acc = enq && (!full_q || deq);
  assign rd_acc = deq && !empty_q;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    ovf_d   = 1'b0;
    unf_d   = 1'b0;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (wr_acc) tail_d = ptr_inc(tail_q);
      if (rd_acc) head_d = ptr_inc(head_q);
      count_d = count_q + CNT_WIDTH'(wr_acc) - CNT_WIDTH'(rd_acc);
      ovf_d   = enq && full_q && !deq;
      unf_d   = deq && empty_q;
    end
    // Flags come from the next count so they move on the same edge as count.
    empty_d = (count_d == '0);
    full_d  = (count_d == CNT_WIDTH'(DEPTH));
    af_d    = (count_d >= CNT_WIDTH'(AF_LEVEL));
    ae_d    = (count_d <= CNT_WIDTH'(AE_LEVEL));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
      af_q    <= 1'b0;
      ae_q    <= 1'b1;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      empty_q <= empty_d;
      full_q  <= full_d;
      af_q    <= af_d;
      ae_q    <= ae_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Storage is not cleared by reset or flush; pointers alone define validity.
  always_ff @(posedge clk) begin
    if (!reset && !flush && wr_acc) mem_q[tail_q] <= in_data;
  end

  assign out_data     = mem_q[head_q];
  assign empty        = empty_q;
  assign full         = full_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

endmodule

// File: tb/tb_rcp_fifo_flex.sv
// Bench for rcp_fifo_flex (DEPTH=5, AF_LEVEL=4, AE_LEVEL=1): vector table,
// reset corner sequence and random traffic against a queue-based reference.
module tb_rcp_fifo_flex;

  localparam int W  = 8;
  localparam int D  = 5;
  localparam int AF = 4;
  localparam int AE = 1;
  localparam int CW = $clog2(D + 1);

  logic          clk = 1'b0;
  logic          reset;
  logic [W-1:0]  in_data;
  logic          enq, deq, flush;
  logic [W-1:0]  out_data;
  logic          empty, full, almost_full, almost_empty;
  logic [CW-1:0] count;
  logic          overflow, underflow;

  rcp_fifo_flex #(.WIDTH(W), .DEPTH(D), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .enq(enq), .deq(deq),
    .flush(flush), .out_data(out_data), .empty(empty), .full(full),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  // Reference state: stored words in order plus the expected error pulses.
  logic [W-1:0] exp_q[$];
  logic         m_ovf, m_unf;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic         enq, deq, flush;
    logic [W-1:0] data;
    int           cnt;
    logic         emp, ful, af, ae, ovf, unf;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add_vec(input logic e, input logic d, input logic f, input logic [W-1:0] dat,
                         input int c, input logic em, input logic fu, input logic af,
                         input logic ae, input logic ov, input logic un);
    vec_t v;
    v.enq = e; v.deq = d; v.flush = f; v.data = dat; v.cnt = c;
    v.emp = em; v.ful = fu; v.af = af; v.ae = ae; v.ovf = ov; v.unf = un;
    vecs.push_back(v);
  endtask

  // Called #1 after a posedge: drives one cycle, checks the head word being
  // presented, advances the reference, then waits for the edge to land.
  task automatic do_cycle(input logic e, input logic d, input logic f, input logic [W-1:0] dat);
    enq = e; deq = d; flush = f; in_data = dat;
    #1;
    if (exp_q.size() > 0) chk("out_data", int'(out_data), int'(exp_q[0]));
    if (f) begin
      exp_q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      m_ovf = e && !d && (exp_q.size() == D);
      m_unf = d && (exp_q.size() == 0);
      if (d && exp_q.size() > 0) void'(exp_q.pop_front());
      if (e && (exp_q.size() < D)) exp_q.push_back(dat);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_model(input string tag);
    int c;
    c = exp_q.size();
    chk({tag, " count"},     int'(count),        c);
    chk({tag, " empty"},     int'(empty),        int'(c == 0));
    chk({tag, " full"},      int'(full),         int'(c == D));
    chk({tag, " a_full"},    int'(almost_full),  int'(c >= AF));
    chk({tag, " a_empty"},   int'(almost_empty), int'(c <= AE));
    chk({tag, " overflow"},  int'(overflow),     int'(m_ovf));
    chk({tag, " underflow"}, int'(underflow),    int'(m_unf));
  endtask

  task automatic do_reset();
    reset = 1'b1; enq = 0; deq = 0; flush = 0; in_data = '0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_q.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  initial begin
    reset = 1'b1; enq = 0; deq = 0; flush = 0; in_data = '0;
    m_ovf = 0; m_unf = 0;

    // enq deq flush data | count empty full af ae ovf unf
    add_vec(0,0,0,8'h00, 0,1,0,0,1,0,0);
    add_vec(1,0,0,8'h01, 1,0,0,0,1,0,0);
    add_vec(1,0,0,8'h02, 2,0,0,0,0,0,0);
    add_vec(1,0,0,8'h03, 3,0,0,0,0,0,0);
    add_vec(1,0,0,8'h04, 4,0,0,1,0,0,0);
    add_vec(1,0,0,8'h05, 5,0,1,1,0,0,0);
    add_vec(1,0,0,8'h06, 5,0,1,1,0,1,0);
    add_vec(1,0,0,8'h07, 5,0,1,1,0,1,0);
    add_vec(0,0,0,8'h00, 5,0,1,1,0,0,0);
    for (int i = 0; i < 10; i++) add_vec(1,1,0,8'hAA, 5,0,1,1,0,0,0);
    add_vec(0,1,0,8'h00, 4,0,0,1,0,0,0);
    add_vec(0,1,0,8'h00, 3,0,0,0,0,0,0);
    add_vec(0,1,0,8'h00, 2,0,0,0,0,0,0);
    add_vec(0,1,0,8'h00, 1,0,0,0,1,0,0);
    add_vec(0,1,0,8'h00, 0,1,0,0,1,0,0);
    add_vec(0,1,0,8'h00, 0,1,0,0,1,0,1);
    add_vec(1,1,0,8'h3C, 1,0,0,0,1,0,1);
    add_vec(0,1,0,8'h00, 0,1,0,0,1,0,0);
    add_vec(1,0,0,8'h11, 1,0,0,0,1,0,0);
    add_vec(1,0,0,8'h22, 2,0,0,0,0,0,0);
    add_vec(1,0,0,8'h33, 3,0,0,0,0,0,0);
    add_vec(1,0,1,8'h44, 0,1,0,0,1,0,0);
    add_vec(1,0,0,8'h77, 1,0,0,0,1,0,0);
    add_vec(0,1,0,8'h00, 0,1,0,0,1,0,0);
    add_vec(0,1,1,8'h00, 0,1,0,0,1,0,0);

    do_reset();
    chk("reset count",     int'(count),        0);
    chk("reset empty",     int'(empty),        1);
    chk("reset full",      int'(full),         0);
    chk("reset a_full",    int'(almost_full),  0);
    chk("reset a_empty",   int'(almost_empty), 1);
    chk("reset overflow",  int'(overflow),     0);
    chk("reset underflow", int'(underflow),    0);

    foreach (vecs[i]) begin
      do_cycle(vecs[i].enq, vecs[i].deq, vecs[i].flush, vecs[i].data);
      chk($sformatf("vec%0d count", i),     int'(count),        vecs[i].cnt);
      chk($sformatf("vec%0d empty", i),     int'(empty),        int'(vecs[i].emp));
      chk($sformatf("vec%0d full", i),      int'(full),         int'(vecs[i].ful));
      chk($sformatf("vec%0d a_full", i),    int'(almost_full),  int'(vecs[i].af));
      chk($sformatf("vec%0d a_empty", i),   int'(almost_empty), int'(vecs[i].ae));
      chk($sformatf("vec%0d overflow", i),  int'(overflow),     int'(vecs[i].ovf));
      chk($sformatf("vec%0d underflow", i), int'(underflow),    int'(vecs[i].unf));
    end

    // Reset mid-stream: stored entries vanish, next write is the new head.
    do_cycle(1, 0, 0, 8'hC1);
    do_cycle(1, 0, 0, 8'hC2);
    do_cycle(1, 0, 0, 8'hC3);
    reset = 1'b1; enq = 1'b1; deq = 1'b0; in_data = 8'hEE;
    @(posedge clk);
    #1;
    reset = 1'b0; enq = 1'b0;
    exp_q.delete(); m_ovf = 0; m_unf = 0;
    chk("midreset count", int'(count), 0);
    chk("midreset empty", int'(empty), 1);
    do_cycle(1, 0, 0, 8'h5A);
    chk("post-reset head", int'(out_data), 8'h5A);
    chk_model("post-reset");
    do_cycle(0, 1, 0, 8'h00);
    chk_model("post-reset drain");

    // Random traffic with phases biased toward filling and draining.
    for (int i = 0; i < 4000; i++) begin
      int pe, pd;
      pe = ((i / 200) % 2 == 0) ? 70 : 30;
      pd = 100 - pe;
      do_cycle($urandom_range(0, 99) < pe, $urandom_range(0, 99) < pd,
               $urandom_range(0, 99) < 2, W'($urandom_range(0, 255)));
      chk_model("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rcp_fifo_flex.md
# rcp_fifo_flex

Parametrised synchronous FIFO for the RCP router datapath; next generation of the router's small enqueue/dequeue queue. Supports arbitrary (non-power-of-two) depth, first-word-fall-through read, occupancy count, programmable almost-full/almost-empty levels, a synchronous flush, and one-cycle overflow/underflow error pulses for the router's statistics counters. Sits between header-processing stages and per-port rate-control logic wherever a shallow elastic buffer with back-pressure hints is needed.

## Interface
- WIDTH, 8, data width in bits (≥1)
- DEPTH, 4, number of entries (≥2, any integer; not limited to powers of two)
- AF_LEVEL, DEPTH-1, almost_full asserted when count ≥ AF_LEVEL (1..DEPTH)
- AE_LEVEL, 1, almost_empty asserted when count ≤ AE_LEVEL (0..DEPTH-1)
- Derived: ADD_WIDTH = ceil(log2(DEPTH)); CNT_WIDTH = ceil(log2(DEPTH+1))

- clk  in  1  single clock; all logic on rising edge
- reset  in  1  synchronous, active-high; one clock, synchronous active-high reset
- in_data  in  WIDTH  write data
- enq  in  1  write request
- deq  in  1  read request (acknowledges current out_data)
- flush  in  1  synchronous clear of contents, keeps configuration
- out_data  out  WIDTH  head entry, show-ahead
- empty  out  1  no valid entries
- full  out  1  DEPTH entries held
- almost_full  out  1  count ≥ AF_LEVEL
- almost_empty  out  1  count ≤ AE_LEVEL
- count  out  CNT_WIDTH  number of valid entries
- overflow  out  1  one-cycle pulse: write dropped
- underflow  out  1  one-cycle pulse: read while empty

## Operation
- Storage: DEPTH×WIDTH array; head (read) and tail (write) pointers, ADD_WIDTH bits, wrap from DEPTH-1 to 0 explicitly (no power-of-two modulo).
- Priority per edge: reset > flush > enq/deq.
- Reset/flush: head=tail=0, count=0, empty=1, full=0, almost_empty=1 (AE_LEVEL≥0), almost_full=0, overflow=underflow=0. Array contents not cleared.
- Write accepted when enq && (!full || deq): entry[tail]←in_data, tail advances.
- Read accepted when deq && !empty: head advances.
- count_next = count + wr_acc − rd_acc; empty/full/almost_* are registered and derived from count_next, so all flags change on the same edge as count.
- enq && deq while full: both accepted, count unchanged, full stays 1, no overflow.
- enq && deq while empty: write accepted, read ignored, count 0→1, underflow pulses.
- enq && !deq while full: write dropped, state unchanged, overflow pulses.
- deq while empty (no enq): nothing changes, underflow pulses.
- Flush concurrent with enq/deq: enq/deq ignored, no error pulses.
- out_data = entry[head] combinationally; valid only when empty=0; undefined when empty.

## Timing
- Write latency: enq sampled at edge N → empty=0, count updated after edge N; data visible on out_data from cycle N+1 when FIFO was empty.
- Read: deq at edge N consumes current out_data; next entry presented after edge N.
- overflow/underflow: registered, high for exactly the cycle after the offending edge; consecutive offending edges give consecutive high cycles.
- All outputs reset values: empty=1, almost_empty=1, full=0, almost_full=0, count=0, overflow=0, underflow=0.
- Reset asserted mid-stream discards all entries at that edge; first enq after reset release is stored at index 0.

## Test plan
- Reset then idle → empty=1, full=0, count=0, almost_empty=1, no pulses.
- DEPTH=5, AF_LEVEL=4, AE_LEVEL=1: enq 0x01..0x05 on consecutive cycles → count 1..5, almost_empty drops when count=2, almost_full rises when count=4, full=1 after fifth; sixth enq → overflow high one cycle, count stays 5.
- Full FIFO, enq 0xAA with deq for 10 cycles → full stays 1, count=5, out_data sequence 0x01..0x05 then 0xAA.., pointers wrap through index 4→0 correctly.
- Empty FIFO, enq 0x3C with deq same cycle → underflow pulse, count=1, out_data=0x3C next cycle.
- Fill to 3 entries, assert flush with enq → count=0, empty=1, no overflow; subsequent enq 0x77 appears on out_data next cycle.
- Random enq/deq 10k cycles against scoreboard model, DEPTH in {2,4,5,7} → data order, count, flags and pulses match every cycle.
